// File: rtl/de_selector_pkg.sv
// Shared defaults and select-width helper for the de_selector block.
package de_selector_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_CH    = 4;

  // Smallest select width w such that 2**w >= ch.
  function automatic int sel_width(input int ch);
    int w;
    w = 1;
    while ((1 << w) < ch) w++;
    return w;
  endfunction

endpackage

// File: rtl/de_selector_slot.sv
// Single output channel: one-entry data register plus full flag with load/drain.
module de_selector_slot
  import de_selector_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iData,
  input  logic             iReady,
  output logic [WIDTH-1:0] oData,
  output logic             oValid,
  output logic             oFree
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  // A load in the same cycle as a drain keeps the slot full with the new word.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (iLoad) begin
      r_full <= 1'b1;
      r_data <= iData;
    end else if (r_full && iReady) begin
      r_full <= 1'b0;
    end
  end

  assign oFree  = ~r_full | iReady;
  assign oData  = r_data;
  assign oValid = r_full;

endmodule

// File: rtl/de_selector_reg.sv
// Registered 1-to-CH demultiplexer with per-channel handshake, broadcast and
// out-of-range error pulse.
module de_selector_reg
  import de_selector_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CH    = DEF_CH,
  parameter int SELW  = sel_width(DEF_CH)
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic [WIDTH-1:0]    iC,
  input  logic [SELW-1:0]     iS,
  input  logic                iBcast,
  input  logic                iValid,
  output logic                oReady,
  output logic [CH*WIDTH-1:0] oZ,
  output logic [CH-1:0]       oValid,
  input  logic [CH-1:0]       iReady,
  output logic                oErr
);

  logic [CH-1:0] w_sel;
  logic [CH-1:0] w_free;
  logic [CH-1:0] w_load;
  logic          w_oob;
  logic          w_tgt_free;
  logic          w_accept;
  logic          r_err;

  // One-hot decode avoids indexing past CH when iS is out of range.
  always_comb begin
    w_sel = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      w_sel[k] = (int'(iS) == int'(k));
    end
  end

  assign w_oob      = (int'(iS) >= CH);
  assign w_tgt_free = |(w_sel & w_free);
  assign oReady     = iBcast ? (&w_free) : (w_oob | w_tgt_free);
  assign w_accept   = iValid & oReady;
  assign w_load     = {CH{w_accept}} & (iBcast ? {CH{1'b1}} : w_sel);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept & ~iBcast & w_oob;
    end
  end

  assign oErr = r_err;

  for (genvar g = 0; g < CH; g++) begin : g_slot
    de_selector_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .iClk  (iClk),
      .iRst_n(iRst_n),
      .iLoad (w_load[g]),
      .iData (iC),
      .iReady(iReady[g]),
      .oData (oZ[g*WIDTH +: WIDTH]),
      .oValid(oValid[g]),
      .oFree (w_free[g])
    );
  end

endmodule

// File: tb/tb_de_selector_reg.sv
// Self-checking bench: directed table, corner sequences and random traffic
// on a 4-channel and a 3-channel instance against a per-channel array model.
module tb_de_selector_reg;

  localparam int W   = 8;
  localparam int CH  = 4;
  localparam int CH3 = 3;

  logic iClk   = 1'b0;
  logic iRst_n = 1'b0;
  always #5 iClk = ~iClk;

  logic [W-1:0]    a_c;   logic [1:0] a_s;   logic a_bc, a_v;  logic [CH-1:0]  a_rdy;
  logic            a_ordy; logic [CH*W-1:0]  a_z; logic [CH-1:0]  a_ov;  logic a_err;
  logic [W-1:0]    b_c;   logic [1:0] b_s;   logic b_bc, b_v;  logic [CH3-1:0] b_rdy;
  logic            b_ordy; logic [CH3*W-1:0] b_z; logic [CH3-1:0] b_ov;  logic b_err;

  de_selector_reg #(.WIDTH(W), .CH(CH), .SELW(2)) dut_a (
    .iClk(iClk), .iRst_n(iRst_n), .iC(a_c), .iS(a_s), .iBcast(a_bc), .iValid(a_v),
    .oReady(a_ordy), .oZ(a_z), .oValid(a_ov), .iReady(a_rdy), .oErr(a_err));

  de_selector_reg #(.WIDTH(W), .CH(CH3), .SELW(2)) dut_b (
    .iClk(iClk), .iRst_n(iRst_n), .iC(b_c), .iS(b_s), .iBcast(b_bc), .iValid(b_v),
    .oReady(b_ordy), .oZ(b_z), .oValid(b_ov), .iReady(b_rdy), .oErr(b_err));

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 = 4-channel instance, 1 = 3-channel instance.
  logic         m_full[2][16];
  logic [W-1:0] m_data[2][16];
  logic         m_err[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_err[d] = 1'b0;
      for (int k = 0; k < 16; k++) begin
        m_full[d][k] = 1'b0;
        m_data[d][k] = '0;
      end
    end
  endtask

  function automatic logic m_ready(input int d, input int ch, input logic bc, input int s,
                                   input logic [15:0] rdy);
    logic r;
    if (bc) begin
      r = 1'b1;
      for (int k = 0; k < ch; k++) if (m_full[d][k] && !rdy[k]) r = 1'b0;
    end else if (s < ch) begin
      r = !m_full[d][s] || rdy[s];
    end else begin
      r = 1'b1;
    end
    return r;
  endfunction

  task automatic m_step(input int d, input int ch, input logic v, input logic bc, input int s,
                        input logic [W-1:0] c, input logic [15:0] rdy);
    logic acc;
    acc = v && m_ready(d, ch, bc, s, rdy);
    for (int k = 0; k < ch; k++) begin
      if (acc && (bc || s == k)) begin
        m_full[d][k] = 1'b1;
        m_data[d][k] = c;
      end else if (m_full[d][k] && rdy[k]) begin
        m_full[d][k] = 1'b0;
      end
    end
    m_err[d] = acc && !bc && (s >= ch);
  endtask

  function automatic logic [63:0] m_valid(input int d, input int ch);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < ch; k++) r[k] = m_full[d][k];
    return r;
  endfunction

  function automatic logic [63:0] m_z(input int d, input int ch);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < ch; k++) r[k*W +: W] = m_data[d][k];
    return r;
  endfunction

  // Called at posedge+1 with inputs already applied; returns at next posedge+1.
  task automatic tick();
    #3;
    check("a_ready", 64'(a_ordy), 64'(m_ready(0, CH,  a_bc, int'(a_s), 16'(a_rdy))));
    check("b_ready", 64'(b_ordy), 64'(m_ready(1, CH3, b_bc, int'(b_s), 16'(b_rdy))));
    @(posedge iClk);
    m_step(0, CH,  a_v, a_bc, int'(a_s), a_c, 16'(a_rdy));
    m_step(1, CH3, b_v, b_bc, int'(b_s), b_c, 16'(b_rdy));
    #1;
    check("a_valid", 64'(a_ov),  m_valid(0, CH));
    check("a_z",     64'(a_z),   m_z(0, CH));
    check("a_err",   64'(a_err), 64'(m_err[0]));
    check("b_valid", 64'(b_ov),  m_valid(1, CH3));
    check("b_z",     64'(b_z),   m_z(1, CH3));
    check("b_err",   64'(b_err), 64'(m_err[1]));
  endtask

  typedef struct {
    logic       v;
    logic       bc;
    logic [1:0] s;
    logic [7:0] c;
    logic [3:0] rdy;
    logic       xr;
    logic [3:0] xv;
    logic [31:0] xz;
  } vec_t;

  vec_t tbl[10];

  initial begin
    a_c = '0; a_s = '0; a_bc = 1'b0; a_v = 1'b0; a_rdy = '0;
    b_c = '0; b_s = '0; b_bc = 1'b0; b_v = 1'b0; b_rdy = '0;
    m_reset();

    tbl[0] = '{1'b1, 1'b0, 2'd2, 8'h01, 4'b0000, 1'b1, 4'b0100, 32'h00010000};
    tbl[1] = '{1'b1, 1'b0, 2'd2, 8'h55, 4'b0000, 1'b0, 4'b0100, 32'h00010000};
    tbl[2] = '{1'b1, 1'b0, 2'd2, 8'h55, 4'b0100, 1'b1, 4'b0100, 32'h00550000};
    tbl[3] = '{1'b0, 1'b0, 2'd2, 8'h00, 4'b0100, 1'b1, 4'b0000, 32'h00550000};
    tbl[4] = '{1'b1, 1'b1, 2'd0, 8'hA1, 4'b0000, 1'b1, 4'b1111, 32'hA1A1A1A1};
    tbl[5] = '{1'b1, 1'b0, 2'd0, 8'h33, 4'b1110, 1'b0, 4'b0001, 32'hA1A1A1A1};
    tbl[6] = '{1'b1, 1'b1, 2'd0, 8'h44, 4'b0000, 1'b0, 4'b0001, 32'hA1A1A1A1};
    tbl[7] = '{1'b1, 1'b0, 2'd3, 8'h77, 4'b0000, 1'b1, 4'b1001, 32'h77A1A1A1};
    tbl[8] = '{1'b1, 1'b1, 2'd0, 8'h99, 4'b1001, 1'b1, 4'b1111, 32'h99999999};
    tbl[9] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h99999999};

    repeat (2) @(posedge iClk);
    #1;
    check("rst_a_valid", 64'(a_ov), 64'h0);
    check("rst_a_z",     64'(a_z),  64'h0);
    check("rst_a_err",   64'(a_err), 64'h0);
    check("rst_b_valid", 64'(b_ov), 64'h0);
    iRst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      a_v = tbl[i].v; a_bc = tbl[i].bc; a_s = tbl[i].s; a_c = tbl[i].c; a_rdy = tbl[i].rdy;
      #3;
      check("tbl_ready", 64'(a_ordy), 64'(tbl[i].xr));
      tick();
      check("tbl_valid", 64'(a_ov), 64'(tbl[i].xv));
      check("tbl_z",     64'(a_z),  64'(tbl[i].xz));
    end

    // Back-to-back stream into channel 1 with consumer always ready.
    a_v = 1'b1; a_bc = 1'b0; a_s = 2'd1; a_rdy = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      a_c = 8'(8'h10 + i);
      tick();
      check("stream_valid1", 64'(a_ov[1]), 64'h1);
      check("stream_z1",     64'(a_z[15:8]), 64'(8'(8'h10 + i)));
    end
    a_rdy = '1;
    for (int i = 0; i < 8; i++) begin
      a_s = 2'(i);
      a_c = 8'(8'hC0 + i);
      tick();
      check("rot_z", 64'(a_z[int'(a_s)*W +: W]), 64'(8'(8'hC0 + i)));
    end
    a_v = 1'b0;
    tick();

    // Out-of-range unicast on the 3-channel instance.
    b_v = 1'b1; b_bc = 1'b0; b_s = 2'd3; b_c = 8'hEE; b_rdy = '0;
    #3;
    check("oob_ready", 64'(b_ordy), 64'h1);
    tick();
    check("oob_err_hi", 64'(b_err), 64'h1);
    b_v = 1'b0;
    tick();
    check("oob_err_lo", 64'(b_err), 64'h0);

    // Random traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      a_v = ($urandom % 4) != 0; a_bc = ($urandom % 6) == 0; a_s = 2'($urandom);
      a_c = 8'($urandom); a_rdy = 4'($urandom);
      b_v = ($urandom % 4) != 0; b_bc = ($urandom % 6) == 0; b_s = 2'($urandom);
      b_c = 8'($urandom); b_rdy = 3'($urandom);
      tick();
    end

    // Reset asserted between edges with channels 0 and 3 holding words.
    a_v = 1'b0; a_rdy = '1; b_v = 1'b0; b_rdy = '1;
    tick();
    a_v = 1'b1; a_bc = 1'b0; a_rdy = '0; a_s = 2'd0; a_c = 8'h5A;
    tick();
    a_s = 2'd3; a_c = 8'hC3;
    tick();
    check("pre_rst_full", 64'({a_ov[3], a_ov[0]}), 64'h3);
    #2;
    iRst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(a_ov), 64'h0);
    check("async_rst_z",     64'(a_z),  64'h0);
    check("async_rst_b",     64'(b_ov), 64'h0);
    m_reset();
    a_bc = 1'b1;
    #1;
    check("rst_bcast_ready", 64'(a_ordy), 64'h1);
    @(posedge iClk);
    #1;
    check("rst_no_accept", 64'(a_ov), 64'h0);
    iRst_n = 1'b1;
    a_bc = 1'b0; a_s = 2'd1; a_c = 8'hE1; a_rdy = '0;
    tick();
    check("first_accept", 64'(a_ov), 64'h2);
    check("first_accept_z", 64'(a_z[15:8]), 64'hE1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
